// File: rtl/sisc_mem_pkg.sv
// Shared definitions for the memory access controller: state encoding,
// datapath width and the default REQ-phase timeout.
package sisc_mem_pkg;

    localparam int DATA_W          = 16;
    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : sisc_mem_pkg

// File: rtl/mem_timeout_cnt.sv
// 8-bit wait counter for the REQ phase; flags expiry on the cycle whose
// increment would reach TIMEOUT_CYCLES.
module mem_timeout_cnt
    import sisc_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Expire on the ack-less cycle that brings the count up to the limit.
    assign expired_o = inc_i && (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));

endmodule : mem_timeout_cnt

// File: rtl/mem_access_ctrl.sv
// Load/store memory access controller (IDLE/REQ/DONE) with MDR.
// Optional REQ timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl
    import sisc_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                tmo_expired;

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != REQ),
        .inc_i    ((state_q == REQ) && !mem_ack),
        .expired_o(tmo_expired)
    );

    // err is registered on the REQ->DONE transition, so it is high only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_expired;
        end
    end

    assign err = err_q;
`else
    assign tmo_expired = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mdr_q   <= mdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            REQ: begin
                // Ack wins over a coincident timeout.
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                    end
                end else if (tmo_expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = (state_q == REQ) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mdr       = mdr_q;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (default or MEM_TIMEOUT_EN build).
module tb_mem_access_ctrl;
    import sisc_mem_pkg::*;

    localparam int TMO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] mdr;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;
    int done_cnt;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mdr      (mdr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_req", 16'(mem_req), 16'd0);
        chk("rst_we", 16'(mem_we), 16'd0);
        chk("rst_mdr", mdr, 16'h0000);
        rst = 1'b0;
        tick();

        // Load, ack one cycle later
        start = 1'b1; we = 1'b0; addr = 16'h0040; wdata = 16'h5555;
        tick();
        start = 1'b0;
        chk("ld_busy", 16'(busy), 16'd1);
        chk("ld_req", 16'(mem_req), 16'd1);
        chk("ld_we", 16'(mem_we), 16'd0);
        chk("ld_addr", mem_addr, 16'h0040);
        chk("ld_done_early", 16'(done), 16'd0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("ld_done", 16'(done), 16'd1);
        chk("ld_err", 16'(err), 16'd0);
        chk("ld_mdr", mdr, 16'hBEEF);
        chk("ld_req_in_done", 16'(mem_req), 16'd0);
        tick();
        chk("ld_done_pulse", 16'(done), 16'd0);
        chk("ld_idle_busy", 16'(busy), 16'd0);

        // Idle hold and stray ack in IDLE
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("idle_ack_busy", 16'(busy), 16'd0);
        chk("idle_ack_done", 16'(done), 16'd0);
        chk("idle_mdr_hold", mdr, 16'hBEEF);

        // Store with 3 wait cycles, inputs scrambled after start
        start = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h1234;
        tick();
        start = 1'b0; we = 1'b0; addr = 16'hFFFF; wdata = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            chk("st_addr_stable", mem_addr, 16'h0010);
            chk("st_wdata_stable", mem_wdata, 16'h1234);
            chk("st_we", 16'(mem_we), 16'd1);
            chk("st_wait_done", 16'(done), 16'd0);
            tick();
        end
        chk("st_addr_last", mem_addr, 16'h0010);
        chk("st_req_last", 16'(mem_req), 16'd1);
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("st_done", 16'(done), 16'd1);
        chk("st_mdr_kept", mdr, 16'hBEEF);
        chk("st_we_in_done", 16'(mem_we), 16'd0);
        tick();

        // Second start during REQ and during DONE is ignored
        start = 1'b1; we = 1'b0; addr = 16'h0100;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; addr = 16'h0200;
        tick();
        start = 1'b0;
        chk("busy_start_addr", mem_addr, 16'h0100);
        mem_ack = 1'b1; mem_rdata = 16'hCAFE;
        tick();
        mem_ack = 1'b0;
        chk("busy_start_done", 16'(done), 16'd1);
        chk("busy_start_mdr", mdr, 16'hCAFE);
        start = 1'b1; addr = 16'h0300;
        tick();
        start = 1'b0;
        chk("done_start_ignored", 16'(busy), 16'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("single_done", 16'(done_cnt), 16'd0);

        // Reset in the middle of REQ
        start = 1'b1; we = 1'b0; addr = 16'h0050;
        tick();
        start = 1'b0;
        chk("mid_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", 16'(mem_req), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_mdr", mdr, 16'h0000);
        chk("mid_rst_addr", mem_addr, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 1'b0;
        chk("post_rst_ack_busy", 16'(busy), 16'd0);
        chk("post_rst_ack_mdr", mdr, 16'h0000);

        // Reset beats a simultaneous start
        rst = 1'b1; start = 1'b1; addr = 16'h0060;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 16'(busy), 16'd0);
        tick();

`ifdef MEM_TIMEOUT_EN
        // Ack coincident with timeout completes normally
        start = 1'b1; we = 1'b0; addr = 16'h0070;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("tmo_ack_pre_done", 16'(done), 16'd0);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        chk("tmo_ack_done", 16'(done), 16'd1);
        chk("tmo_ack_err", 16'(err), 16'd0);
        chk("tmo_ack_mdr", mdr, 16'h7777);
        tick();

        // No ack: abort after TMO REQ cycles
        start = 1'b1; we = 1'b0; addr = 16'h0080;
        tick();
        start = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_wait_done", 16'(done), 16'd0);
            chk("tmo_wait_req", 16'(mem_req), 16'd1);
            tick();
        end
        chk("tmo_done", 16'(done), 16'd1);
        chk("tmo_err", 16'(err), 16'd1);
        chk("tmo_mdr", mdr, 16'h7777);
        tick();
        chk("tmo_err_clear", 16'(err), 16'd0);
        chk("tmo_idle", 16'(busy), 16'd0);
`else
        // Without timeout REQ waits indefinitely
        start = 1'b1; we = 1'b0; addr = 16'h0070;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("wait_busy", 16'(busy), 16'd1);
        chk("wait_req", 16'(mem_req), 16'd1);
        chk("wait_done", 16'(done), 16'd0);
        chk("wait_err", 16'(err), 16'd0);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        chk("wait_ack_done", 16'(done), 16'd1);
        chk("wait_ack_err", 16'(err), 16'd0);
        chk("wait_ack_mdr", mdr, 16'h7777);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_access_ctrl
